// File: rtl/cpu_pkg.sv
// Shared CPU definitions: stack operation encoding and the default PC width.
package cpu_pkg;

  localparam int PC_W = 16;

  // Encoding matches the {push, pop} request pair directly.
  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_t;

endpackage

// File: rtl/link_stack_ram.sv
// DEPTH x WIDTH storage for the link stack: one synchronous write port and
// one asynchronous read port. Contents are never reset.
module link_stack_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write the addressed entry when enabled.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/link_stack.sv
// LIFO of return/loop addresses. CALL/FOR push, RET/loop exit pop,
// FOR loop-back replaces the top. Overflow and underflow are sticky.
module link_stack
  import cpu_pkg::*;
#(
  parameter int WIDTH = PC_W,
  parameter int DEPTH = 8,
  parameter int WRAP  = 0,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  input  logic             clr_err,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    r_wp;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_udf;

  stack_op_t        w_op;
  logic [AW-1:0]    w_top_addr;
  logic [WIDTH-1:0] w_rdata;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_wp_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_ovf_set;
  logic             w_udf_set;
  logic             w_empty;
  logic             w_full;

  assign w_op       = stack_op_t'({push, pop});
  assign w_top_addr = r_wp - 1'b1;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);

  // Decode the requested operation into pointer, count, write and error updates.
  always_comb begin
    w_we        = 1'b0;
    w_waddr     = r_wp;
    w_wp_nxt    = r_wp;
    w_count_nxt = r_count;
    w_ovf_set   = 1'b0;
    w_udf_set   = 1'b0;
    unique case (w_op)
      OP_PUSH: begin
        if (!w_full) begin
          w_we        = 1'b1;
          w_wp_nxt    = r_wp + 1'b1;
          w_count_nxt = r_count + 1'b1;
        end else begin
          w_ovf_set = 1'b1;
          // Circular mode overwrites the oldest entry; count stays at DEPTH.
          if (WRAP != 0) begin
            w_we     = 1'b1;
            w_wp_nxt = r_wp + 1'b1;
          end
        end
      end
      OP_POP: begin
        if (!w_empty) begin
          w_wp_nxt    = r_wp - 1'b1;
          w_count_nxt = r_count - 1'b1;
        end else begin
          w_udf_set = 1'b1;
        end
      end
      OP_REPLACE: begin
        w_we = 1'b1;
        if (!w_empty) begin
          w_waddr = w_top_addr;
        end else begin
          // Nothing to replace: fall back to a plain push and flag it.
          w_wp_nxt    = r_wp + 1'b1;
          w_count_nxt = r_count + 1'b1;
          w_udf_set   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Control state: pointer, count and sticky flags (a new error beats clr_err).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_wp    <= w_wp_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_set | (r_ovf & ~clr_err);
      r_udf   <= w_udf_set | (r_udf & ~clr_err);
    end
  end

  link_stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we & ~rst),
    .i_waddr (w_waddr),
    .i_wdata (push_data),
    .i_raddr (w_top_addr),
    .o_rdata (w_rdata)
  );

  assign top       = w_empty ? '0 : w_rdata;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_ovf;
  assign underflow = r_udf;

endmodule

// File: tb/tb_link_stack.sv
// Directed bench for link_stack: one saturating and one circular instance
// share the same stimulus.
module tb_link_stack;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [W-1:0]  push_data = '0;
  logic          clr_err = 1'b0;

  logic [W-1:0]  top0, top1;
  logic [CW-1:0] count0, count1;
  logic          empty0, empty1, full0, full1;
  logic          ovf0, ovf1, udf0, udf1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  link_stack #(.WIDTH(W), .DEPTH(D), .WRAP(0)) u_sat (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .clr_err(clr_err), .top(top0), .count(count0), .empty(empty0),
    .full(full0), .overflow(ovf0), .underflow(udf0)
  );

  link_stack #(.WIDTH(W), .DEPTH(D), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .clr_err(clr_err), .top(top1), .count(count1), .empty(empty1),
    .full(full1), .overflow(ovf1), .underflow(udf1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then release them 1 time unit after the edge.
  task automatic step(input logic p, input logic po, input logic [W-1:0] d,
                      input logic c, input logic r);
    push = p; pop = po; push_data = d; clr_err = c; rst = r;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; push_data = '0; clr_err = 1'b0; rst = 1'b0;
  endtask

  initial begin
    #2;
    step(0, 0, 0, 0, 1);
    chk("rst_top", top0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_count", count0, 0);
    chk("rst_full", full0, 0);
    chk("rst_flags", {ovf0, udf0}, 0);

    // Pop on empty
    step(0, 1, 0, 0, 0);
    chk("udf_pop_empty", udf0, 1);
    chk("udf_count", count0, 0);
    // clr_err with a fresh underflow: set wins
    step(0, 1, 0, 1, 0);
    chk("clr_set_wins", udf0, 1);
    step(0, 0, 0, 1, 0);
    chk("clr_alone", udf0, 0);

    // Basic push/pop
    step(1, 0, 16'h0005, 0, 0);
    step(1, 0, 16'h0011, 0, 0);
    step(1, 0, 16'h0023, 0, 0);
    chk("basic_top0", top0, 16'h0023);
    chk("basic_count", count0, 3);
    step(0, 1, 0, 0, 0);
    chk("basic_top1", top0, 16'h0011);
    step(0, 1, 0, 0, 0);
    chk("basic_top2", top0, 16'h0005);
    step(0, 1, 0, 0, 0);
    chk("basic_top3", top0, 0);
    chk("basic_empty", empty0, 1);
    chk("basic_flags", {ovf0, udf0}, 0);

    // Fill past capacity: saturating vs circular
    for (int i = 1; i <= 9; i++) step(1, 0, W'(i), 0, 0);
    chk("sat_full", full0, 1);
    chk("sat_count", count0, 8);
    chk("sat_ovf", ovf0, 1);
    chk("sat_top", top0, 8);
    chk("wrap_top9", top1, 9);
    step(1, 0, 16'd10, 0, 0);
    chk("sat_top_after10", top0, 8);
    chk("wrap_count", count1, 8);
    chk("wrap_ovf", ovf1, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("sat_pop%0d", i), top0, 32'(8 - i));
      chk($sformatf("wrap_pop%0d", i), top1, 32'(10 - i));
      step(0, 1, 0, 0, 0);
    end
    chk("sat_empty_after", empty0, 1);
    chk("wrap_empty_after", empty1, 1);
    chk("wrap_top_empty", top1, 0);
    chk("wrap_no_udf", udf1, 0);
    step(0, 0, 0, 1, 0);
    chk("ovf_cleared", {ovf0, ovf1}, 0);

    // Replace
    step(1, 0, 16'h0040, 0, 0);
    step(1, 1, 16'h0041, 0, 0);
    chk("repl_top", top0, 16'h0041);
    chk("repl_count", count0, 1);
    chk("repl_no_udf", udf0, 0);
    step(0, 1, 0, 0, 0);
    chk("repl_pop_empty", empty0, 1);
    step(1, 1, 16'h0077, 0, 0);
    chk("repl_empty_count", count0, 1);
    chk("repl_empty_udf", udf0, 1);
    chk("repl_empty_top", top0, 16'h0077);

    // Reset mid-operation beats a push
    step(1, 0, 16'h0088, 0, 0);
    step(1, 0, 16'h0099, 0, 0);
    chk("pre_rst_count", count0, 3);
    step(1, 0, 16'h00AA, 0, 1);
    chk("mid_rst_count", count0, 0);
    chk("mid_rst_top", top0, 0);
    chk("mid_rst_udf", udf0, 0);
    chk("mid_rst_empty", empty1, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/link_stack.md
# link_stack

Parametrised LIFO of return/loop addresses that replaces the processor's single return register (RR). CALL and FOR push an address, RET and loop exit pop it, so nested calls and nested FOR loops become possible. The block sits in the datapath between the PC-next logic and the PC source mux. It also reports overflow and underflow to the controller as sticky error flags.

## Interface
Parameters:
- WIDTH, 16, bit width of each entry (PC width).
- DEPTH, 8, number of entries; power of two, ≥ 2.
- WRAP, 0, overflow policy: 0 = saturate (drop the push), 1 = circular (overwrite the oldest entry).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- push  in  1  push push_data this cycle.
- pop  in  1  pop the top entry this cycle.
- push_data  in  WIDTH  value to push (PC+1 for CALL, PC for FOR).
- clr_err  in  1  clears overflow and underflow.
- top  out  WIDTH  current top entry; 0 when empty.
- count  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky; set by a push while full.
- underflow  out  1  sticky; set by a pop while empty.

## Operation
- State:
  - Storage array mem[DEPTH].
  - Write pointer wp, $clog2(DEPTH) bits, arithmetic modulo DEPTH.
  - count.
  - overflow and underflow flags.
- top = mem[(wp-1) mod DEPTH] when count ≠ 0, else 0.
- Per-cycle action, decoded from {push, pop}:
  - NOP (0,0): no change.
  - PUSH (1,0), not full: mem[wp] ← push_data, wp+1, count+1.
  - PUSH while full, WRAP=0: no storage change; overflow ← 1.
  - PUSH while full, WRAP=1: mem[wp] ← push_data, wp+1, count stays DEPTH; overflow ← 1. The oldest entry is lost.
  - POP (0,1), not empty: wp−1, count−1. Storage is not cleared.
  - POP while empty: no change; underflow ← 1.
  - REPLACE (1,1), not empty: mem[wp−1] ← push_data; wp and count unchanged. Used for the FOR loop-back path.
  - REPLACE while empty: behaves as PUSH; underflow ← 1.
- clr_err clears both flags. If the same cycle raises a new error, set wins: the flag is 1 after the edge.
- Storage holds no valid data after the last pop. Popping past the count never exposes stale entries: top reads 0 when empty.

## Timing
- All state updates on the rising edge of clk.
- top, count, empty and full are combinational from registered state. There is zero read latency: top reflects a push or pop one edge after it is requested.
- push_data is sampled at the edge.
- Reset values, on the edge with rst=1: wp=0, count=0, overflow=0, underflow=0. Outputs: top=0, empty=1, full=0. Storage is not reset.
- rst has priority over push, pop and clr_err. A reset mid-sequence discards all entries.
- Wrap-around: wp rolls DEPTH−1 → 0 on push and 0 → DEPTH−1 on pop. count never exceeds DEPTH and never goes below 0.
- Single-cycle CALL→RET is allowed: push in cycle n, pop in cycle n+1 returns the pushed value on top during cycle n+1.

## Structure
- Shared package cpu_pkg holds:
  - typedef stack_op_t {OP_NOP, OP_PUSH, OP_POP, OP_REPLACE}, decoded from {push, pop}.
  - The default PC width constant, 16.
- One sub-module, link_stack_ram: DEPTH×WIDTH array with one synchronous write port and one asynchronous read port.
- Pointer, count and flag logic stay in link_stack.

## Test plan
- Reset then idle: after rst, top=0, empty=1, count=0; a pop sets underflow=1 and count stays 0.
- Push 0x0005, 0x0011, 0x0023, then pop ×3: top reads 0x0023, 0x0011, 0x0005, then 0; empty=1; no flags set.
- DEPTH=8, WRAP=0: push 1..9; full=1, count=8, overflow=1, top=8; 8 pops return 8..1.
- DEPTH=8, WRAP=1: push 1..10; count=8, overflow=1; pops return 10,9,…,3, then empty=1.
- Replace: push 0x0040, then push=pop=1 with 0x0041; top=0x0041, count=1. Same op while empty: count=1 and underflow=1.
- Error clear and reset mid-operation:
  - clr_err together with a pop on empty leaves underflow=1; clr_err alone clears it.
  - rst asserted with push=1 and count=3 gives count=0, top=0.
